mdu: RTL and testbench

Iterative multiply/divide unit for the RV32/RV64 M extension. It sits beside the integer execute stage: the decoder sends it MUL/DIV/REM-class instructions, and its result joins the write-back mux. It replaces single-cycle combinational multiply and divide with a radix-2^UNROLL shift-add/restoring datapath. It uses a valid/ready handshake on both sides and adds a flush input for pipeline kills.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 41 ++++
 rtl/mdu.sv | 199 +++++++++++++++++++
 tb/tb_mdu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: M-extension
// funct3 encodings, FSM state type and the CALC iteration count helper.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CALC iterations for an operating width and unroll factor.
  function automatic int iter_count(input int width, input int unroll);
    return width / unroll;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath. Multiply consumes the MSB of
// the shift register and does shift-then-add into the accumulator; divide
// shifts the next dividend bit into the partial remainder (low half of the
// accumulator), compares against the divisor and shifts the quotient bit in.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   sreg,
  input  logic [XLEN-1:0]   opd,
  output logic [2*XLEN-1:0] acc_next,
  output logic [XLEN-1:0]   sreg_next
);

  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   diff;
  logic              fits;
  logic [2*XLEN-1:0] opd_wide;

  // Single add-shift or compare-subtract-shift step.
  always_comb begin
    trial     = {acc[XLEN-1:0], sreg[XLEN-1]};
    fits      = (trial >= {1'b0, opd});
    // When the divisor fits the difference is below opd, so XLEN bits suffice.
    diff      = trial[XLEN-1:0] - opd;
    opd_wide  = {{XLEN{1'b0}}, opd};
    acc_next  = '0;
    sreg_next = '0;
    if (is_div) begin
      acc_next  = {{XLEN{1'b0}}, (fits ? diff : trial[XLEN-1:0])};
      sreg_next = {sreg[XLEN-2:0], fits};
    end else begin
      acc_next  = (acc << 1) + (sreg[XLEN-1] ? opd_wide : '0);
      sreg_next = {sreg[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative M-extension multiply/divide unit. Operands are converted to
// magnitudes on accept, left-aligned in a shift register so word and full
// width ops share one MSB-first datapath, iterated UNROLL bits per cycle,
// and sign-corrected on the transition into DONE.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data
);

  localparam int N_FULL = iter_count(XLEN, UNROLL);
  localparam int N_WORD = iter_count(32, UNROLL);
  localparam int CW     = $clog2(N_FULL) + 1;
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_t state, state_n;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   sreg;
  logic [XLEN-1:0]   opd;
  logic              is_div;
  logic              is_rem;
  logic              hi_sel;
  logic              word_r;
  logic              neg_res;

  logic              word_op;
  logic [2:0]        funct;
  logic              sgn_a, sgn_b;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_raw, special_res;
  logic              accept;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_mag, div_signed, calc_raw, calc_res;

  logic [2*XLEN-1:0] step_acc;
  logic [XLEN-1:0]   step_sreg;

  // Request decode: operand extension, magnitudes and special-case results.
  always_comb begin
    word_op = (XLEN > 32) && in_word;
    // Word multiplies other than MULW are not decoded upstream; run them as MULW.
    funct   = (word_op && !in_funct3[2]) ? MDU_MUL : in_funct3;
    sgn_a   = (funct == MDU_MUL) || (funct == MDU_MULH) || (funct == MDU_MULHSU) ||
              (funct == MDU_DIV) || (funct == MDU_REM);
    sgn_b   = (funct == MDU_MUL) || (funct == MDU_MULH) ||
              (funct == MDU_DIV) || (funct == MDU_REM);
    a_ext   = in_rs1;
    b_ext   = in_rs2;
    if (word_op) begin
      a_ext = sgn_a ? XLEN'($signed(in_rs1[31:0])) : XLEN'(in_rs1[31:0]);
      b_ext = sgn_b ? XLEN'($signed(in_rs2[31:0])) : XLEN'(in_rs2[31:0]);
    end
    a_neg    = sgn_a && a_ext[XLEN-1];
    b_neg    = sgn_b && b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = funct[2] && (b_ext == '0);
    div_ovf  = funct[2] && !funct[0] && (b_ext == '1) &&
               (a_ext == (word_op ? MIN_WORD : MIN_FULL));
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_raw = funct[1] ? a_ext : '1;
    end else begin
      special_raw = funct[1] ? '0 : a_ext;
    end
    special_res = word_op ? XLEN'($signed(special_raw[31:0])) : special_raw;
  end

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    prod       = neg_res ? -acc : acc;
    div_mag    = is_rem ? acc[XLEN-1:0] : sreg;
    div_signed = neg_res ? -div_mag : div_mag;
    if (is_div) begin
      calc_raw = div_signed;
    end else begin
      calc_raw = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
    calc_res = word_r ? XLEN'($signed(calc_raw[31:0])) : calc_raw;
  end

  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    logic [2*XLEN-1:0] acc_cur, acc_nxt;
    logic [XLEN-1:0]   sreg_cur, sreg_nxt;
    if (k == 0) begin : g_first
      assign acc_cur  = acc;
      assign sreg_cur = sreg;
    end else begin : g_chain
      assign acc_cur  = g_step[k-1].acc_nxt;
      assign sreg_cur = g_step[k-1].sreg_nxt;
    end
    mdu_step #(.XLEN(XLEN)) u_step (
      .is_div    (is_div),
      .acc       (acc_cur),
      .sreg      (sreg_cur),
      .opd       (opd),
      .acc_next  (acc_nxt),
      .sreg_next (sreg_nxt)
    );
  end

  assign step_acc  = g_step[UNROLL-1].acc_nxt;
  assign step_sreg = g_step[UNROLL-1].sreg_nxt;

  assign accept = in_valid && (state == IDLE) && !flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; flush wins over everything, including a pending accept.
  always_comb begin
    state_n  = state;
    in_ready = (state == IDLE);
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_n = special ? DONE : CALC;
        CALC:    if (cnt == '0) state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand capture, iteration, and registered result/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      sreg      <= '0;
      opd       <= '0;
      is_div    <= 1'b0;
      is_rem    <= 1'b0;
      hi_sel    <= 1'b0;
      word_r    <= 1'b0;
      neg_res   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state_n == DONE);
      if (accept) begin
        is_div  <= funct[2];
        is_rem  <= funct[2] && funct[1];
        hi_sel  <= !funct[2] && (funct != MDU_MUL);
        word_r  <= word_op;
        neg_res <= (funct[2] && funct[1]) ? a_neg : (a_neg ^ b_neg);
        acc     <= '0;
        cnt     <= word_op ? CW'(N_WORD) : CW'(N_FULL);
        // Word operands sit in the top 32 bits so the step always reads the MSB.
        if (funct[2]) begin
          sreg <= word_op ? (a_mag << (XLEN - 32)) : a_mag;
          opd  <= b_mag;
        end else begin
          sreg <= word_op ? (b_mag << (XLEN - 32)) : b_mag;
          opd  <= a_mag;
        end
        if (special) begin
          out_data <= special_res;
        end
      end else if ((state == CALC) && !flush) begin
        if (cnt != '0) begin
          acc  <= step_acc;
          sreg <= step_sreg;
          cnt  <= cnt - CW'(1);
        end else begin
          out_data <= calc_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: two instances (UNROLL=1 and UNROLL=4) share
// the stimulus; an arithmetic reference model predicts every result and
// latency, and a negedge compare process checks valid/data every cycle.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready, in_word;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1, in_rs2;
  logic        in_ready1, out_valid1, in_ready4, out_valid4;
  logic [63:0] out_data1, out_data4;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu #(.XLEN(64), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_funct3(in_funct3), .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  mdu #(.XLEN(64), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_funct3(in_funct3), .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain wide arithmetic, RISC-V special cases spelled out.
  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  a32, b32, r32;
    longint       sa, sb;
    int           sa32, sb32;
    if (!f[2]) begin
      if (w) begin
        r32 = a[31:0] * b[31:0];
        return {{32{r32[31]}}, r32};
      end
      ea = (f == 3'b011) ? {64'b0, a} : {{64{a[63]}}, a};
      eb = f[1] ? {64'b0, b} : {{64{b[63]}}, b};
      p  = ea * eb;
      return (f == 3'b000) ? p[63:0] : p[127:64];
    end
    if (!w) begin
      sa = a;
      sb = b;
      if (b == 64'd0) return f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      if (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        return f[1] ? 64'd0 : a;
      if (!f[0]) return f[1] ? 64'(sa % sb) : 64'(sa / sb);
      return f[1] ? (a % b) : (a / b);
    end
    a32  = a[31:0];
    b32  = b[31:0];
    sa32 = a32;
    sb32 = b32;
    if (b32 == 32'd0) r32 = f[1] ? a32 : 32'hFFFF_FFFF;
    else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = f[1] ? 32'd0 : a32;
    else if (!f[0]) r32 = f[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
    else r32 = f[1] ? (a32 % b32) : (a32 / b32);
    return {{32{r32[31]}}, r32};
  endfunction

  // Edges from the accept edge until out_valid is first visible.
  function automatic int model_lat(input logic [2:0] f, input logic w, input logic [63:0] a,
                                   input logic [63:0] b, input int unroll);
    logic sp;
    if (w) sp = f[2] && ((b[31:0] == 32'd0) ||
                (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF));
    else   sp = f[2] && ((b == 64'd0) ||
                (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return sp ? 0 : ((w ? 32 : 64) / unroll + 1);
  endfunction

  logic        pend [2];
  logic [63:0] exp_d [2];
  int          exp_lat [2];
  int          acc_cyc [2];
  logic [1:0]  ov, ir;
  logic [63:0] od [2];
  logic        exp_v;

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
  end

  // Compare process: out_valid every cycle, out_data whenever valid.
  always @(negedge clk) begin
    ov    = {out_valid4, out_valid1};
    ir    = {in_ready4, in_ready1};
    od[0] = out_data1;
    od[1] = out_data4;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        chk($sformatf("valid_in_reset_u%0d", k), ov[k], 0);
      end else begin
        exp_v = pend[k] && ((cyc - acc_cyc[k]) >= exp_lat[k]);
        chk($sformatf("valid_u%0d", k), ov[k], exp_v);
        if (ov[k] && exp_v) begin
          chk($sformatf("data_u%0d", k), od[k], exp_d[k]);
          if (out_ready) pend[k] = 1'b0;
        end
        if (flush) pend[k] = 1'b0;
        if (in_valid && ir[k] && !flush) begin
          pend[k]    = 1'b1;
          exp_d[k]   = model(in_funct3, in_word, in_rs1, in_rs2);
          exp_lat[k] = model_lat(in_funct3, in_word, in_rs1, in_rs2, (k == 0) ? 1 : 4);
          acc_cyc[k] = cyc + 1;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    int t = 0;
    while (!(in_ready1 && in_ready4) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("issue_wait", (t < 300), 1);
    in_funct3 = f;
    in_word   = w;
    in_rs1    = a;
    in_rs2    = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((pend[0] || pend[1]) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_wait", (t < 300), 1);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_word = 1'b0; in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0;

    vecs.push_back('{MDU_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{MDU_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    vecs.push_back('{MDU_DIV,    1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{MDU_REM,    1'b0, 64'd5, 64'd0, 64'd5});
    vecs.push_back('{MDU_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
    vecs.push_back('{MDU_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    vecs.push_back('{MDU_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{MDU_DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{MDU_REM,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{MDU_DIVU,   1'b0, 64'd100, 64'd7, 64'd14});
    vecs.push_back('{MDU_REMU,   1'b0, 64'd100, 64'd7, 64'd2});
    vecs.push_back('{MDU_MUL,    1'b1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFE_0001});
    vecs.push_back('{MDU_DIVU,   1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{MDU_MULH,   1'b1, 64'd3, 64'd5, 64'd15});
    vecs.push_back('{MDU_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1});
    vecs.push_back('{MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{MDU_DIVU,   1'b1, 64'd5, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready_u1",  in_ready1,  1);
    chk("reset_out_valid_u1", out_valid1, 0);
    chk("reset_out_data_u1",  out_data1,  64'd0);
    chk("reset_in_ready_u4",  in_ready4,  1);
    chk("reset_out_valid_u4", out_valid4, 0);
    chk("reset_out_data_u4",  out_data4,  64'd0);
    rst = 1'b0;

    // Pin the model against hand-computed values.
    foreach (vecs[i]) begin
      chk($sformatf("model_v%0d", i), model(vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b), vecs[i].e);
    end
    chk("model_lat_mul",    model_lat(MDU_MUL, 1'b0, 64'd7, 64'd3, 1), 64'd65);
    chk("model_lat_divw",   model_lat(MDU_DIV, 1'b1, 64'd7, 64'd2, 1), 64'd33);
    chk("model_lat_divw_4", model_lat(MDU_DIV, 1'b1, 64'd7, 64'd2, 4), 64'd9);
    chk("model_lat_div0",   model_lat(MDU_DIV, 1'b0, 64'd5, 64'd0, 1), 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b);
      drain();
    end

    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, (i < 6) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom});
      drain();
    end

    // Result held with out_ready low.
    out_ready = 1'b0;
    issue(MDU_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    t = 0;
    while (!out_valid1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("hold_wait", (t < 200), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid1, 1);
      chk("hold_data",  out_data1,  64'hFFFF_FFFF_FFFF_FFFD);
    end
    out_ready = 1'b1;
    drain();

    // Flush at CALC cycle 20 kills the operation.
    issue(MDU_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (19) @(posedge clk);
    #1;
    chk("flush_still_busy", in_ready1, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", in_ready1, 1);
    repeat (80) @(posedge clk);
    #1;

    // flush together with in_valid: nothing accepted.
    in_funct3 = MDU_DIVU; in_word = 1'b0; in_rs1 = 64'd9; in_rs2 = 64'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_accept_u1", in_ready1, 1);
    chk("flush_accept_u4", in_ready4, 1);
    repeat (5) @(posedge clk);
    #1;

    // Reset pulse mid-CALC.
    issue(MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_in_ready_u1",  in_ready1,  1);
    chk("rst_out_valid_u1", out_valid1, 0);
    chk("rst_out_data_u1",  out_data1,  64'd0);
    chk("rst_in_ready_u4",  in_ready4,  1);
    chk("rst_out_valid_u4", out_valid4, 0);
    chk("rst_out_data_u4",  out_data4,  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;

    // Unit still works after the reset.
    issue(MDU_REMU, 1'b0, 64'd100, 64'd7);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
